ahb3lite_host_slave: RTL and testbench
======================================

AHB3LITE_HOST_SLAVE -- requirements
Module: ahb3lite_host_slave

Interface
REQ-001 SHALL have parameter STALL_MAX, default 255, meaning the maximum number of data-phase wait cycles a DATA write may stall on WRFULL before an ERROR response.
REQ-002 SHALL have port CLK  input  1  single clock for all logic.
REQ-003 SHALL have port RESETn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports HSEL, HWRITE  input  1 each  AHB3-lite slave select and write indicator.
REQ-005 SHALL have ports HTRANS[1:0], HSIZE[2:0], HADDR[31:0], HWDATA[31:0]  input  AHB3-lite address-phase and data-phase signals.
REQ-006 SHALL have port HREADY  input  1  bus-wide ready.
REQ-007 SHALL have ports HREADYOUT  output  1, HRESP  output  1 and HRDATA  output  32  slave ready, response and read data.
REQ-008 SHALL have host-FIFO ports RDEN  output  1, RDEMPTY  input  1, RDDATA  input  8, WREN  output  1, WRFULL  input  1, WRDATA  output  8.

Function
REQ-009 SHALL accept an address phase when HSEL & HTRANS[1] & HREADY, latching HADDR[3:0] and HWRITE; otherwise it SHALL leave the slave IDLE with an OKAY, zero-wait response.
REQ-010 SHALL decode word offsets: 0x0 DATA, 0x4 STATUS, 0x8 COUNT; offset 0xC or HADDR[1:0]!=0 SHALL give ERROR; HSIZE SHALL be ignored.
REQ-011 SHALL produce a two-cycle ERROR: ERR1 drives HREADYOUT=0 and HRESP=1, then ERR2 drives HREADYOUT=1 and HRESP=1, then returns to IDLE.
REQ-012 SHALL use states IDLE, RD_POP, RD_DATA, WR_DATA, ERR1 and ERR2; a new address phase SHALL be acceptable in any cycle where HREADYOUT=1.
REQ-013 A DATA read with RDEMPTY=1 at the start of the data phase SHALL complete zero-wait with HRDATA=0x0000_0000.
REQ-014 A DATA read with RDEMPTY=0 SHALL enter RD_POP, asserting RDEN for exactly one cycle with HREADYOUT=0.
REQ-015 After RD_POP, RD_DATA SHALL drive HREADYOUT=1 and HRDATA={23'h0, 1'b1, RDDATA}; total latency is one wait state.
REQ-016 A DATA write SHALL enter WR_DATA; when WRFULL=0 it SHALL assert WREN for one cycle with WRDATA=HWDATA[7:0] and HREADYOUT=1.
REQ-017 While WRFULL=1 in WR_DATA, the block SHALL hold HREADYOUT=0 and increment an 8-bit stall counter.
REQ-018 When the stall counter reaches STALL_MAX, the block SHALL drop the byte, set sticky TIMEOUT and enter ERR1; the stall counter SHALL clear on leaving WR_DATA.
REQ-019 A STATUS read SHALL return {29'h0, TIMEOUT, WRFULL, RDEMPTY}, zero-wait.
REQ-020 A STATUS write with HWDATA[2]=1 SHALL clear TIMEOUT, zero-wait.
REQ-021 The block SHALL keep 16-bit counters rx_cnt, incremented on each RDEN, and tx_cnt, incremented on each WREN; both SHALL wrap 0xFFFF->0x0000.
REQ-022 A COUNT read SHALL return {rx_cnt, tx_cnt}, zero-wait.
REQ-023 A COUNT write of any value SHALL clear both counters.
REQ-024 RDEN and WREN SHALL never both be high, and neither SHALL be asserted outside RD_POP or WR_DATA.
REQ-025 HRDATA SHALL be 0 in every cycle without a read response.
REQ-026 Every data phase of a write SHALL sample HWDATA in the cycle HREADYOUT=1, except the stalled DATA write, which SHALL sample HWDATA in the cycle WREN is asserted.

Reset
REQ-027 On RESETn=0 the block SHALL asynchronously force HREADYOUT=1, HRESP=0, HRDATA=0, RDEN=0, WREN=0, WRDATA=0, state IDLE, TIMEOUT=0, stall counter=0, rx_cnt=0 and tx_cnt=0.
REQ-028 Reset asserted mid-transaction SHALL abandon the pending transfer without any further RDEN or WREN pulse.
REQ-029 After release of reset, the first address phase SHALL be accepted on the next qualifying cycle.

Verification
REQ-030 The bench SHALL cover DATA read with RDEMPTY=0 and RDDATA=0xA5 -> RDEN for one cycle, one wait state, HRDATA=0x0000_01A5, rx_cnt=1.
REQ-031 The bench SHALL cover DATA read with RDEMPTY=1 -> no RDEN, zero-wait OKAY, HRDATA=0.
REQ-032 The bench SHALL cover DATA write 0x1234_5678 with WRFULL=0 -> WREN for one cycle, WRDATA=0x78, tx_cnt=1.
REQ-033 The bench SHALL cover DATA write with WRFULL held high and STALL_MAX=4 -> 4 wait cycles, ERR1/ERR2, no WREN, STATUS reads 0x4 (plus current FIFO flags).
REQ-034 The bench SHALL cover a read of offset 0xC and a read of offset 0x2 -> two-cycle ERROR each, with no FIFO strobes.
REQ-035 The bench SHALL cover 65536 pops followed by a COUNT read -> rx_cnt=0x0000, then a COUNT write -> both counters 0, and reset asserted during RD_POP -> RDEN low immediately with all outputs at reset values.

Source files
------------

// File: rtl/ahb3lite_host_slave.sv
// rtl/ahb3lite_host_slave.sv - AHB3-lite slave bridging DATA/STATUS/COUNT registers to byte-wide host FIFOs
module ahb3lite_host_slave #(
    parameter int STALL_MAX = 255
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        HSEL,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        RDEN,
    input  logic        RDEMPTY,
    input  logic [7:0]  RDDATA,
    output logic        WREN,
    input  logic        WRFULL,
    output logic [7:0]  WRDATA
);
    typedef enum logic [2:0] {IDLE, RD_POP, RD_DATA, WR_DATA, ERR1, ERR2} state_t;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    state_t      state, state_nxt;
    logic        dp_q;
    logic [1:0]  off_q;
    logic        write_q;
    logic        timeout;
    logic [7:0]  stall_cnt;
    logic [15:0] rx_cnt, tx_cnt;
    logic        take;
    logic        set_timeout, clr_timeout, clr_cnt;
    logic [8:0]  stall_inc;

    wire unused_ok = ^{HSIZE, HTRANS[0], HADDR[31:4], HWDATA[31:8]};

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        HRDATA      = 32'h0;
        RDEN        = 1'b0;
        WREN        = 1'b0;
        WRDATA      = 8'h0;
        set_timeout = 1'b0;
        clr_timeout = 1'b0;
        clr_cnt     = 1'b0;
        take        = 1'b0;
        stall_inc   = {1'b0, stall_cnt} + 9'd1;
        case (state)
            IDLE: begin
                // dp_q marks a zero-wait data phase of a register access
                if (dp_q) begin
                    if (write_q) begin
                        clr_timeout = (off_q == OFF_STATUS) && HWDATA[2];
                        clr_cnt     = (off_q == OFF_COUNT);
                    end else if (off_q == OFF_STATUS) begin
                        HRDATA = {29'h0, timeout, WRFULL, RDEMPTY};
                    end else if (off_q == OFF_COUNT) begin
                        HRDATA = {rx_cnt, tx_cnt};
                    end
                end
            end
            RD_POP: begin
                RDEN      = 1'b1;
                HREADYOUT = 1'b0;
                state_nxt = RD_DATA;
            end
            RD_DATA: HRDATA = {23'h0, 1'b1, RDDATA};
            WR_DATA: begin
                if (WRFULL) begin
                    HREADYOUT = 1'b0;
                    if (stall_inc == STALL_MAX[8:0]) begin
                        set_timeout = 1'b1;
                        state_nxt   = ERR1;
                    end
                end else begin
                    WREN   = 1'b1;
                    WRDATA = HWDATA[7:0];
                end
            end
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_nxt = ERR2;
            end
            ERR2: HRESP = 1'b1;
            default: state_nxt = IDLE;
        endcase

        // Any cycle completing a data phase may also carry the next address phase
        if (HREADYOUT) begin
            take      = HSEL & HTRANS[1] & HREADY;
            state_nxt = IDLE;
            if (take) begin
                if ((HADDR[1:0] != 2'b00) || (HADDR[3:2] == 2'd3))
                    state_nxt = ERR1;
                else if (HADDR[3:2] == OFF_DATA)
                    state_nxt = HWRITE ? WR_DATA : (RDEMPTY ? IDLE : RD_POP);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            dp_q      <= 1'b0;
            off_q     <= 2'd0;
            write_q   <= 1'b0;
            timeout   <= 1'b0;
            stall_cnt <= 8'd0;
            rx_cnt    <= 16'd0;
            tx_cnt    <= 16'd0;
        end else begin
            if (HREADYOUT) begin
                dp_q    <= take;
                off_q   <= HADDR[3:2];
                write_q <= HWRITE;
            end
            if (set_timeout)      timeout <= 1'b1;
            else if (clr_timeout) timeout <= 1'b0;
            stall_cnt <= (state == WR_DATA && WRFULL && !set_timeout) ? stall_inc[7:0] : 8'd0;
            if (clr_cnt) begin
                rx_cnt <= 16'd0;
                tx_cnt <= 16'd0;
            end else begin
                rx_cnt <= rx_cnt + {15'd0, RDEN};
                tx_cnt <= tx_cnt + {15'd0, WREN};
            end
        end
    end
endmodule

// File: tb/tb_ahb3lite_host_slave.sv
// tb/tb_ahb3lite_host_slave.sv - directed vector bench for ahb3lite_host_slave
module tb_ahb3lite_host_slave;
    logic        CLK = 1'b0;
    logic        RESETn;
    logic        HSEL, HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HADDR, HWDATA;
    logic        HREADY;
    logic        HREADYOUT, HRESP;
    logic [31:0] HRDATA;
    logic        RDEN, RDEMPTY, WREN, WRFULL;
    logic [7:0]  RDDATA, WRDATA;

    int n_checks = 0;
    int n_fail   = 0;
    int rden_mon = 0;
    int wren_mon = 0;
    logic [7:0] last_wrdata = 8'h0;

    assign HREADY = HREADYOUT;

    always #5 CLK = ~CLK;

    ahb3lite_host_slave #(.STALL_MAX(4)) dut (
        .CLK(CLK), .RESETn(RESETn), .HSEL(HSEL), .HWRITE(HWRITE), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .RDEN(RDEN), .RDEMPTY(RDEMPTY), .RDDATA(RDDATA),
        .WREN(WREN), .WRFULL(WRFULL), .WRDATA(WRDATA)
    );

    always @(negedge CLK) begin
        if (RESETn) begin
            if (RDEN) rden_mon++;
            if (WREN) begin
                wren_mon++;
                last_wrdata = WRDATA;
            end
            n_checks++;
            if (RDEN && WREN) begin
                n_fail++;
                $display("FAIL strobe_excl: RDEN=%0b WREN=%0b required not both high", RDEN, WREN);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic addr_phase(input logic [3:0] a, input logic w);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = {28'h0, a}; HWRITE = w; HSIZE = 3'b010;
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HWRITE = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge ending the data phase
    task automatic xfer(input logic [3:0] a, input logic w, input logic [31:0] wd,
                        output int waits, output logic resp, output logic [31:0] rd);
        bit done;
        addr_phase(a, w);
        @(posedge CLK); #1;
        bus_idle();
        HWDATA = wd;
        waits = 0; done = 0; resp = 1'b0; rd = 32'h0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge CLK);
            if (HREADYOUT) begin
                done = 1; resp = HRESP; rd = HRDATA;
            end else begin
                waits++;
            end
            @(posedge CLK); #1;
        end
        if (!done) waits = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hreadyout"}, {31'h0, HREADYOUT}, 32'h1);
        check({tag, "_hresp"},     {31'h0, HRESP},     32'h0);
        check({tag, "_hrdata"},    HRDATA,             32'h0);
        check({tag, "_rden"},      {31'h0, RDEN},      32'h0);
        check({tag, "_wren"},      {31'h0, WREN},      32'h0);
        check({tag, "_wrdata"},    {24'h0, WRDATA},    32'h0);
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic        rdempty;
        logic [7:0]  rddata;
        logic        wrfull;
        int          waits;
        logic        resp;
        logic [31:0] rdata;
        int          rdens;
        int          wrens;
        logic [7:0]  wrdata;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int waits;
        logic resp;
        logic [31:0] rd;
        int r0, w0;

        vecs[0]  = '{4'h0, 1'b0, 32'h0,        1'b0, 8'hA5, 1'b0, 1, 1'b0, 32'h0000_01A5, 1, 0, 8'h00};
        vecs[1]  = '{4'h0, 1'b0, 32'h0,        1'b1, 8'h5A, 1'b0, 0, 1'b0, 32'h0000_0000, 0, 0, 8'h00};
        vecs[2]  = '{4'h0, 1'b1, 32'h1234_5678, 1'b1, 8'h00, 1'b0, 0, 1'b0, 32'h0000_0000, 0, 1, 8'h78};
        vecs[3]  = '{4'h8, 1'b0, 32'h0,        1'b1, 8'h00, 1'b0, 0, 1'b0, 32'h0001_0001, 0, 0, 8'h00};
        vecs[4]  = '{4'h4, 1'b0, 32'h0,        1'b1, 8'h00, 1'b0, 0, 1'b0, 32'h0000_0001, 0, 0, 8'h00};
        vecs[5]  = '{4'h0, 1'b1, 32'hCAFE_BABE, 1'b1, 8'h00, 1'b1, 5, 1'b1, 32'h0000_0000, 0, 0, 8'h00};
        vecs[6]  = '{4'h4, 1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 0, 1'b0, 32'h0000_0006, 0, 0, 8'h00};
        vecs[7]  = '{4'h4, 1'b1, 32'h0000_0004, 1'b1, 8'h00, 1'b0, 0, 1'b0, 32'h0000_0000, 0, 0, 8'h00};
        vecs[8]  = '{4'h4, 1'b0, 32'h0,        1'b1, 8'h00, 1'b0, 0, 1'b0, 32'h0000_0001, 0, 0, 8'h00};
        vecs[9]  = '{4'hC, 1'b0, 32'h0,        1'b0, 8'h11, 1'b0, 1, 1'b1, 32'h0000_0000, 0, 0, 8'h00};
        vecs[10] = '{4'h2, 1'b0, 32'h0,        1'b0, 8'h22, 1'b0, 1, 1'b1, 32'h0000_0000, 0, 0, 8'h00};
        vecs[11] = '{4'hC, 1'b1, 32'h0000_00EE, 1'b1, 8'h00, 1'b0, 1, 1'b1, 32'h0000_0000, 0, 0, 8'h00};
        vecs[12] = '{4'h0, 1'b0, 32'h0,        1'b0, 8'h3C, 1'b0, 1, 1'b0, 32'h0000_013C, 1, 0, 8'h00};
        vecs[13] = '{4'h8, 1'b0, 32'h0,        1'b1, 8'h00, 1'b0, 0, 1'b0, 32'h0002_0001, 0, 0, 8'h00};
        vecs[14] = '{4'h8, 1'b1, 32'hFFFF_FFFF, 1'b1, 8'h00, 1'b0, 0, 1'b0, 32'h0000_0000, 0, 0, 8'h00};
        vecs[15] = '{4'h8, 1'b0, 32'h0,        1'b1, 8'h00, 1'b0, 0, 1'b0, 32'h0000_0000, 0, 0, 8'h00};

        RESETn = 1'b0; bus_idle(); HSIZE = 3'b010; HWDATA = 32'h0;
        RDEMPTY = 1'b1; RDDATA = 8'h00; WRFULL = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        RESETn = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 16; i++) begin
            RDEMPTY = vecs[i].rdempty; RDDATA = vecs[i].rddata; WRFULL = vecs[i].wrfull;
            r0 = rden_mon; w0 = wren_mon;
            xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, waits, resp, rd);
            check($sformatf("vec%0d_waits", i), waits, vecs[i].waits);
            check($sformatf("vec%0d_resp", i), {31'h0, resp}, {31'h0, vecs[i].resp});
            check($sformatf("vec%0d_hrdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d_rden", i), rden_mon - r0, vecs[i].rdens);
            check($sformatf("vec%0d_wren", i), wren_mon - w0, vecs[i].wrens);
            if (vecs[i].wrens != 0)
                check($sformatf("vec%0d_wrdata", i), {24'h0, last_wrdata}, {24'h0, vecs[i].wrdata});
        end

        // Stalled write released after one wait: byte taken from the WREN cycle
        WRFULL = 1'b1; RDEMPTY = 1'b1;
        addr_phase(4'h0, 1'b1);
        @(posedge CLK); #1;
        bus_idle(); HWDATA = 32'h0000_00AA;
        @(negedge CLK);
        check("stall_hreadyout", {31'h0, HREADYOUT}, 32'h0);
        check("stall_wren", {31'h0, WREN}, 32'h0);
        @(posedge CLK); #1;
        WRFULL = 1'b0; HWDATA = 32'h1122_3344;
        @(negedge CLK);
        check("release_wren", {31'h0, WREN}, 32'h1);
        check("release_wrdata", {24'h0, WRDATA}, 32'h44);
        check("release_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        @(posedge CLK); #1;

        // rx_cnt wrap: preload near the top, then pop three bytes
        force dut.rx_cnt = 16'hFFFD;
        #1;
        release dut.rx_cnt;
        RDEMPTY = 1'b0; RDDATA = 8'h01;
        for (int k = 0; k < 3; k++) xfer(4'h0, 1'b0, 32'h0, waits, resp, rd);
        RDEMPTY = 1'b1;
        xfer(4'h8, 1'b0, 32'h0, waits, resp, rd);
        check("wrap_count", rd, 32'h0000_0001);
        xfer(4'h8, 1'b1, 32'h0, waits, resp, rd);
        xfer(4'h8, 1'b0, 32'h0, waits, resp, rd);
        check("count_clear", rd, 32'h0000_0000);

        // Reset during RD_POP
        RDEMPTY = 1'b0; RDDATA = 8'h77;
        addr_phase(4'h0, 1'b0);
        @(posedge CLK); #1;
        bus_idle();
        check("pop_rden", {31'h0, RDEN}, 32'h1);
        r0 = rden_mon;
        #2 RESETn = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK); #1;
        xfer(4'h8, 1'b0, 32'h0, waits, resp, rd);
        check("postreset_waits", waits, 0);
        check("postreset_count", rd, 32'h0000_0000);
        check("postreset_no_rden", rden_mon - r0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
